// File: rtl/exe_stage_mc.sv
// ============================================================================
// exe_stage_mc : execute stage with registered EX/MEM outputs, 1-cycle ALU
//                and iterative shift-add unsigned multiply with HI write-back
// Revision     : 1.0
// ============================================================================
`default_nettype none

module exe_stage_mc #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHAMT_W    = $clog2(DATA_W)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [7:0]            aluop_i,
  input  logic [2:0]            alusel_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic                  stall_o,
  output logic                  valid_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic                  hi_we_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(DATA_W - 1);

  state_t                  state_q, state_d;
  logic [SHAMT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]     mcand_q, mcand_d;
  logic [DATA_W-1:0]       mplier_q, mplier_d;
  logic [2*DATA_W-1:0]     acc_q, acc_d;
  logic [REG_ADDR_W-1:0]   lwd_q, lwd_d;
  logic                    lwreg_q, lwreg_d;
  logic                    valid_q, valid_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [REG_ADDR_W-1:0]   wd_q, wd_d;
  logic                    wreg_q, wreg_d;
  logic [DATA_W-1:0]       hi_q, hi_d;
  logic                    hi_we_q, hi_we_d;

  logic                    is_mul;
  logic [DATA_W-1:0]       alu_res;
  logic                    alu_known;
  logic [SHAMT_W-1:0]      shamt;

  assign is_mul = (alusel_i == 3'b101) && (aluop_i == 8'h19);
  assign shamt  = reg1_i[SHAMT_W-1:0];

  always_comb begin
    alu_res   = '0;
    alu_known = 1'b1;
    case ({alusel_i, aluop_i})
      {3'b001, 8'h25}: alu_res = reg1_i | reg2_i;
      {3'b001, 8'h24}: alu_res = reg1_i & reg2_i;
      {3'b001, 8'h26}: alu_res = reg1_i ^ reg2_i;
      {3'b001, 8'h27}: alu_res = ~(reg1_i | reg2_i);
      {3'b010, 8'h7C}: alu_res = reg2_i << shamt;
      {3'b010, 8'h02}: alu_res = reg2_i >> shamt;
      {3'b010, 8'h03}: alu_res = $signed(reg2_i) >>> shamt;
      {3'b100, 8'h20}: alu_res = reg1_i + reg2_i;
      {3'b100, 8'h22}: alu_res = reg1_i - reg2_i;
      {3'b100, 8'h2A}: alu_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      default:         alu_known = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    lwd_d    = lwd_q;
    lwreg_d  = lwreg_q;
    valid_d  = 1'b0;
    wdata_d  = '0;
    wd_d     = '0;
    wreg_d   = 1'b0;
    hi_d     = hi_q;
    hi_we_d  = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && is_mul) begin
            mcand_d  = {{DATA_W{1'b0}}, reg1_i};
            mplier_d = reg2_i;
            acc_d    = '0;
            cnt_d    = '0;
            lwd_d    = wd_i;
            lwreg_d  = wreg_i;
            state_d  = BUSY;
          end else if (valid_i) begin
            valid_d = 1'b1;
            wdata_d = alu_res;
            wd_d    = wd_i;
            wreg_d  = wreg_i & alu_known;
          end
        end
        BUSY: begin
          // one multiplier bit per cycle, LSB first
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + SHAMT_W'(1);
          if (cnt_q == CNT_LAST) state_d = DONE;
        end
        DONE: begin
          valid_d = 1'b1;
          wdata_d = acc_q[DATA_W-1:0];
          hi_d    = acc_q[2*DATA_W-1:DATA_W];
          hi_we_d = 1'b1;
          wd_d    = lwd_q;
          wreg_d  = lwreg_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      lwd_q    <= '0;
      lwreg_q  <= 1'b0;
      valid_q  <= 1'b0;
      wdata_q  <= '0;
      wd_q     <= '0;
      wreg_q   <= 1'b0;
      hi_q     <= '0;
      hi_we_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      lwd_q    <= lwd_d;
      lwreg_q  <= lwreg_d;
      valid_q  <= valid_d;
      wdata_q  <= wdata_d;
      wd_q     <= wd_d;
      wreg_q   <= wreg_d;
      hi_q     <= hi_d;
      hi_we_q  <= hi_we_d;
    end
  end

  assign stall_o = resetn & (((state_q == IDLE) & valid_i & is_mul) | (state_q == BUSY));
  assign valid_o = valid_q;
  assign wdata_o = wdata_q;
  assign wd_o    = wd_q;
  assign wreg_o  = wreg_q;
  assign hi_o    = hi_q;
  assign hi_we_o = hi_we_q;

endmodule

`default_nettype wire

// File: tb/tb_exe_stage_mc.sv
// ============================================================================
// tb_exe_stage_mc : directed stimulus with queue scoreboard for exe_stage_mc
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_exe_stage_mc;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [7:0]  aluop_i = '0;
  logic [2:0]  alusel_i = '0;
  logic [31:0] reg1_i = '0;
  logic [31:0] reg2_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] wdata_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] hi_o;
  logic        hi_we_o;

  exe_stage_mc #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .resetn(resetn), .flush_i(flush_i), .valid_i(valid_i),
    .aluop_i(aluop_i), .alusel_i(alusel_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .stall_o(stall_o), .valid_o(valid_o),
    .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o), .hi_o(hi_o), .hi_we_o(hi_we_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] hi;
    logic        hi_we;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          vlog[$];
  logic [31:0] exp_hi = '0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per valid_o cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (resetn && valid_o) begin
        vlog.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid_o=1 with wdata %h, expected none", wdata_o);
        end else begin
          e = sb.pop_front();
          cmp("wdata_o", wdata_o, e.wdata);
          cmp("wd_o", {27'd0, wd_o}, {27'd0, e.wd});
          cmp("wreg_o", {31'd0, wreg_o}, {31'd0, e.wreg});
          cmp("hi_o", hi_o, e.hi);
          cmp("hi_we_o", {31'd0, hi_we_o}, {31'd0, e.hi_we});
        end
      end
    end
  end

  // Holds the instruction until stall_o drops; returns number of stall cycles.
  task automatic issue(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic w,
                       output int st);
    logic s;
    logic done;
    alusel_i = sel; aluop_i = op; reg1_i = a; reg2_i = b; wd_i = d; wreg_i = w;
    valid_i = 1'b1;
    st = 0;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      s = stall_o;
      if (s) st++;
      @(posedge clk);
      #1;
      if (!s) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) cmp("issue_timeout", 32'd1, 32'd0);
    valid_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] wdata, input logic [4:0] d, input logic w, input logic hwe);
    exp_t e;
    e.wdata = wdata; e.wd = d; e.wreg = w; e.hi = exp_hi; e.hi_we = hwe;
    sb.push_back(e);
  endtask

  initial begin
    int st;
    int n;
    repeat (3) @(posedge clk);
    #1;
    valid_i = 1'b1; alusel_i = 3'b101; aluop_i = 8'h19;
    @(negedge clk);
    cmp("reset_stall", {31'd0, stall_o}, 32'd0);
    cmp("reset_valid", {31'd0, valid_o}, 32'd0);
    cmp("reset_wdata", wdata_o, 32'd0);
    cmp("reset_hi", hi_o, 32'd0);
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // LOGIC NOR
    push(32'h00000F0F, 5'd5, 1'b1, 1'b0);
    issue(3'b001, 8'h27, 32'hF0F0F0F0, 32'h0F0F0000, 5'd5, 1'b1, st);
    cmp("nor_stall_cycles", st, 32'd0);

    // SHIFTS
    push(32'hF8000001, 5'd6, 1'b1, 1'b0);
    issue(3'b010, 8'h03, 32'd4, 32'h80000010, 5'd6, 1'b1, st);
    push(32'h08000001, 5'd7, 1'b1, 1'b0);
    issue(3'b010, 8'h02, 32'd4, 32'h80000010, 5'd7, 1'b1, st);
    push(32'h80000000, 5'd8, 1'b1, 1'b0);
    issue(3'b010, 8'h7C, 32'd31, 32'd1, 5'd8, 1'b1, st);
    @(posedge clk);
    #1;

    // ARITH back-to-back
    n = vlog.size();
    push(32'd1, 5'd10, 1'b1, 1'b0);
    issue(3'b100, 8'h2A, 32'hFFFFFFFF, 32'd1, 5'd10, 1'b1, st);
    push(32'hFFFFFFFF, 5'd11, 1'b1, 1'b0);
    issue(3'b100, 8'h22, 32'd0, 32'd1, 5'd11, 1'b1, st);
    push(32'd0, 5'd12, 1'b1, 1'b0);
    issue(3'b100, 8'h20, 32'hFFFFFFFF, 32'd1, 5'd12, 1'b1, st);
    repeat (2) @(posedge clk);
    #1;
    cmp("arith_valid_count", vlog.size() - n, 32'd3);
    if (vlog.size() >= n + 3) begin
      cmp("arith_consecutive_1", vlog[n+1] - vlog[n], 32'd1);
      cmp("arith_consecutive_2", vlog[n+2] - vlog[n+1], 32'd1);
    end

    // MULTU 0xFFFFFFFF * 2
    exp_hi = 32'd1;
    push(32'hFFFFFFFE, 5'd9, 1'b1, 1'b1);
    issue(3'b101, 8'h19, 32'hFFFFFFFF, 32'd2, 5'd9, 1'b1, st);
    cmp("multu_stall_cycles", st, 32'd33);

    // HI holds across a non-multiply op
    push(32'h0000000F, 5'd3, 1'b1, 1'b0);
    issue(3'b001, 8'h26, 32'h000000F0, 32'h000000FF, 5'd3, 1'b1, st);

    // MULTU 7*6 flushed in its 10th BUSY cycle
    alusel_i = 3'b101; aluop_i = 8'h19; reg1_i = 32'd7; reg2_i = 32'd6; wd_i = 5'd4; wreg_i = 1'b1;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    cmp("busy10_stall", {31'd0, stall_o}, 32'd1);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    exp_hi = 32'd0;
    @(negedge clk);
    cmp("flush_stall", {31'd0, stall_o}, 32'd0);
    cmp("flush_valid", {31'd0, valid_o}, 32'd0);
    cmp("flush_hi_we", {31'd0, hi_we_o}, 32'd0);
    cmp("flush_hi", hi_o, 32'd0);
    repeat (40) @(negedge clk);
    cmp("flush_no_late_hi_we", {31'd0, hi_we_o}, 32'd0);
    @(posedge clk);
    #1;
    push(32'd7, 5'd2, 1'b1, 1'b0);
    issue(3'b100, 8'h20, 32'd3, 32'd4, 5'd2, 1'b1, st);

    // Reset in the middle of a MULTU
    alusel_i = 3'b101; aluop_i = 8'h19; reg1_i = 32'd5; reg2_i = 32'd5; wd_i = 5'd1; wreg_i = 1'b1;
    valid_i = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reg1_i = 32'hDEADBEEF; reg2_i = 32'h12345678; wd_i = 5'd31;
    resetn = 1'b0;
    @(negedge clk);
    cmp("in_reset_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    cmp("post_reset_stall", {31'd0, stall_o}, 32'd0);
    cmp("post_reset_valid", {31'd0, valid_o}, 32'd0);
    cmp("post_reset_wdata", wdata_o, 32'd0);
    cmp("post_reset_wd", {27'd0, wd_o}, 32'd0);
    repeat (40) @(negedge clk);
    cmp("post_reset_no_hi_we", {31'd0, hi_we_o}, 32'd0);
    @(posedge clk);
    #1;

    // Unlisted opcode
    push(32'd0, 5'd13, 1'b0, 1'b0);
    issue(3'b001, 8'hFF, 32'h12345678, 32'h9ABCDEF0, 5'd13, 1'b1, st);
    cmp("unlisted_stall_cycles", st, 32'd0);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    cmp("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
